// File: rtl/mdr_mem_pkg.sv
// Shared definitions for the MDR/MAR memory port: state encoding,
// default widths and the timeout counter width.
package mdr_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  // TIMEOUT is limited to 1..255, so 8 bits cover every terminal count
  localparam int TMR_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;

endpackage

// File: rtl/mem_wait_timer.sv
// Acknowledge-wait timer: cleared when a transaction starts, counts while
// the port waits, and flags the terminal count TIMEOUT-1 combinationally.
module mem_wait_timer
  import mdr_mem_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  input  logic run,
  output logic expired
);

  localparam logic [TMR_W-1:0] TERM = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt;

  // restart wins over run; stop at the terminal count so the counter never wraps
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                  cnt <= '0;
    else if (restart)         cnt <= '0;
    else if (run && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == TERM);

endmodule

// File: rtl/mdr_mem_port.sv
// Memory-side datapath stage: holds MAR/MDR for the bus mux and runs a
// req/ack handshake to the unified RAM, with a timeout on missing acks.
module mdr_mem_port
  import mdr_mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_start,
  input  logic              wr_start,
  output logic [DATA_W-1:0] mdr_q,
  output logic [ADDR_W-1:0] mar_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              start_ok;
  logic              tmr_exp;

  // a start is only accepted from IDLE; read takes precedence over write
  assign start_ok = (state == ST_IDLE) && (rd_start || wr_start);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
    .clk     (clk),
    .clr     (clr),
    .restart (start_ok),
    .run     (state != ST_IDLE),
    .expired (tmr_exp)
  );

  // control FSM plus MAR/MDR and registered memory-side outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      mar       <= '0;
      mdr       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // loads land together with a start; the start sees the old values
          if (mar_in) mar <= bus_in[ADDR_W-1:0];
          if (mdr_in) mdr <= bus_in;
          if (rd_start) begin
            state    <= ST_RD_WAIT;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= mar;
            busy     <= 1'b1;
            err      <= 1'b0;
          end else if (wr_start) begin
            state     <= ST_WR_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= mar;
            mem_wdata <= mdr;
            busy      <= 1'b1;
            err       <= 1'b0;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          // an ack on the terminal-count cycle still counts as success
          if (mem_ack) begin
            if (state == ST_RD_WAIT) mdr <= mem_rdata;
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else if (tmr_exp) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mdr_q = mdr;
  assign mar_q = mar;

endmodule

// File: tb/tb_mdr_mem_port.sv
// Scoreboard bench for mdr_mem_port with TIMEOUT=4: each transaction pushes
// its expected outcome at start and pops it when done is observed.
module tb_mdr_mem_port;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus_in;
  logic        mar_in, mdr_in, rd_start, wr_start;
  logic [31:0] mdr_q;
  logic [8:0]  mar_q;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy, done, err;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] mdr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  mdr_mem_port #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(4)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .rd_start(rd_start), .wr_start(wr_start), .mdr_q(mdr_q), .mar_q(mar_q),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // advance one edge and settle; inputs set after this are sampled next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mar_in = 0; mdr_in = 0; rd_start = 0; wr_start = 0; mem_ack = 0;
  endtask

  task automatic test_reset();
    clr = 1; bus_in = '0; mem_rdata = '0; idle_inputs();
    step();
    checks++;
    if ({mdr_q, mar_q, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err} !== '0)
      $display("FAIL reset_state mdr=%h mar=%h req=%b busy=%b done=%b err=%b, want all 0",
               mdr_q, mar_q, mem_req, busy, done, err);
    else passed++;
    clr = 0;
    rd_start = 1;
    step();
    rd_start = 0;
    step();                         // now in 2nd wait cycle
    clr = 1; #1;
    checks++;
    if ({mdr_q, mar_q, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err} !== '0)
      $display("FAIL reset_mid_read req=%b busy=%b done=%b err=%b, want all 0",
               mem_req, busy, done, err);
    else passed++;
    step(); clr = 0;
    mem_rdata = 32'hDEAD_BEEF; mem_ack = 1;
    step();
    mem_ack = 0;
    checks++;
    if (mdr_q !== 32'h0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL late_ack mdr=%h done=%b busy=%b, want mdr=0 done=0 busy=0", mdr_q, done, busy);
    else passed++;
  endtask

  task automatic test_read();
    bus_in = 32'h0000_005A; mar_in = 1;
    step();
    mar_in = 0;
    rd_start = 1;
    sb.push_back('{"read", 1'b0, 9'h05A, 32'h1234_5678, 1'b0});
    step();
    rd_start = 0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'h05A || busy !== 1'b1)
      $display("FAIL read_req req=%b we=%b addr=%h busy=%b, want 1 0 05a 1", mem_req, mem_we, mem_addr, busy);
    else passed++;
    step(); step();
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b1)
      $display("FAIL read_wait done=%b req=%b, want 0 1", done, mem_req);
    else passed++;
    mem_rdata = 32'h1234_5678; mem_ack = 1;
    step();
    mem_ack = 0;
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || mdr_q !== e.mdr || err !== e.err || mem_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_end done=%b mdr=%h err=%b req=%b busy=%b, want 1 %h %b 0 0",
               e.name, done, mdr_q, err, mem_req, busy, e.mdr, e.err);
    else passed++;
    step();
    checks++;
    if (done !== 1'b0)
      $display("FAIL read_done_pulse done=%b, want 0", done);
    else passed++;
  endtask

  task automatic test_write();
    // MAR and MDR loaded in the same cycle from one bus value
    bus_in = 32'hCAFE_01FF; mar_in = 1; mdr_in = 1;
    step();
    mar_in = 0;
    bus_in = 32'hCAFE_0001;
    step();
    mdr_in = 0;
    checks++;
    if (mar_q !== 9'h1FF || mdr_q !== 32'hCAFE_0001)
      $display("FAIL write_load mar=%h mdr=%h, want 1ff cafe0001", mar_q, mdr_q);
    else passed++;
    // write uses the old MDR while the new bus value is also loaded
    wr_start = 1; mdr_in = 1; bus_in = 32'h5555_AAAA;
    sb.push_back('{"write", 1'b1, 9'h1FF, 32'h5555_AAAA, 1'b0});
    step();
    wr_start = 0; mdr_in = 0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_0001 || mem_addr !== sb[0].addr)
      $display("FAIL write_req req=%b we=%b wdata=%h addr=%h, want 1 1 cafe0001 1ff",
               mem_req, mem_we, mem_wdata, mem_addr);
    else passed++;
    mem_ack = 1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_ack = 0;
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || mdr_q !== e.mdr || err !== e.err)
      $display("FAIL %s_end done=%b mdr=%h err=%b, want 1 %h %b", e.name, done, mdr_q, err, e.mdr, e.err);
    else passed++;
    // restore MDR for later tests
    bus_in = 32'hCAFE_0001; mdr_in = 1;
    step();
    mdr_in = 0;
  endtask

  task automatic test_timeout();
    int  cyc;
    bit  seen;
    rd_start = 1;
    sb.push_back('{"timeout", 1'b0, 9'h1FF, 32'hCAFE_0001, 1'b1});
    step();
    rd_start = 0;
    cyc = 0; seen = 0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      step();
      if (done) begin seen = 1; cyc = i; end
    end
    checks++;
    if (!seen || cyc != 4)
      $display("FAIL timeout_latency seen=%0d cycles=%0d, want done 4 cycles after req", seen, cyc);
    else passed++;
    e = sb.pop_front();
    checks++;
    if (err !== e.err || mdr_q !== e.mdr || mem_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_end err=%b mdr=%h req=%b busy=%b, want %b %h 0 0",
               e.name, err, mdr_q, mem_req, busy, e.err, e.mdr);
    else passed++;
    step();
    checks++;
    if (err !== 1'b1)
      $display("FAIL err_sticky err=%b, want 1", err);
    else passed++;
    wr_start = 1;
    step();
    wr_start = 0;
    checks++;
    if (err !== 1'b0 || mem_req !== 1'b1 || mem_we !== 1'b1)
      $display("FAIL err_clear err=%b req=%b we=%b, want 0 1 1", err, mem_req, mem_we);
    else passed++;
    mem_ack = 1;
    step();
    mem_ack = 0;
    // ack on the terminal-count cycle: success wins
    rd_start = 1;
    sb.push_back('{"ack_at_timeout", 1'b0, 9'h1FF, 32'h7777_0004, 1'b0});
    step();
    rd_start = 0;
    step(); step(); step();
    mem_ack = 1; mem_rdata = 32'h7777_0004;
    step();
    mem_ack = 0;
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || err !== e.err || mdr_q !== e.mdr)
      $display("FAIL %s_end done=%b err=%b mdr=%h, want 1 %b %h", e.name, done, err, mdr_q, e.err, e.mdr);
    else passed++;
  endtask

  task automatic test_lockout();
    rd_start = 1;
    sb.push_back('{"lockout", 1'b0, 9'h1FF, 32'h0BAD_F00D, 1'b0});
    step();
    rd_start = 0;
    bus_in = 32'hFFFF_FFFF; mdr_in = 1; mar_in = 1; wr_start = 1;
    step();
    mdr_in = 0; mar_in = 0; wr_start = 0;
    checks++;
    if (mdr_q !== 32'h7777_0004 || mar_q !== 9'h1FF || mem_we !== 1'b0 || mem_req !== 1'b1)
      $display("FAIL lockout_hold mdr=%h mar=%h we=%b req=%b, want 77770004 1ff 0 1",
               mdr_q, mar_q, mem_we, mem_req);
    else passed++;
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    step();
    mem_ack = 0;
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || mdr_q !== e.mdr || err !== e.err)
      $display("FAIL %s_end done=%b mdr=%h err=%b, want 1 %h %b", e.name, done, mdr_q, err, e.mdr, e.err);
    else passed++;
    step();
    checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0)
      $display("FAIL lockout_no_write req=%b busy=%b, want 0 0", mem_req, busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    rd_start = 1; wr_start = 1;
    sb.push_back('{"simul", 1'b0, 9'h1FF, 32'h1111_2222, 1'b0});
    step();
    rd_start = 0; wr_start = 0;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== sb[0].we)
      $display("FAIL simul_read req=%b we=%b, want 1 0", mem_req, mem_we);
    else passed++;
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    step();
    mem_ack = 0;
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || mdr_q !== e.mdr)
      $display("FAIL %s_end done=%b mdr=%h, want 1 %h", e.name, done, mdr_q, e.mdr);
    else passed++;
    rd_start = 1;                  // issued in the done cycle
    sb.push_back('{"b2b", 1'b0, 9'h1FF, 32'h3333_4444, 1'b0});
    step();
    rd_start = 0;
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept req=%b busy=%b done=%b, want 1 1 0", mem_req, busy, done);
    else passed++;
    mem_ack = 1; mem_rdata = 32'h3333_4444;
    step();
    mem_ack = 0;
    e = sb.pop_front();
    checks++;
    if (done !== 1'b1 || mdr_q !== e.mdr || err !== e.err)
      $display("FAIL %s_end done=%b mdr=%h err=%b, want 1 %h %b", e.name, done, mdr_q, err, e.mdr, e.err);
    else passed++;
    checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_empty left=%0d, want 0", sb.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_lockout();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
